// File: rtl/grf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority, MDU results
// wait in a small FIFO and drain in idle, unpaused cycles; WAW squash via live bits.
module grf_wb_arbiter #(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pause,
   input  logic        pipe_we,
   input  logic [4:0]  pipe_adr,
   input  logic [31:0] pipe_wd,
   input  logic [31:0] pipe_pc,
   input  logic        mdu_valid,
   output logic        mdu_ready,
   input  logic [4:0]  mdu_adr,
   input  logic [31:0] mdu_wd,
   input  logic [31:0] mdu_pc,
   output logic        reg_we,
   output logic [4:0]  reg_adr3,
   output logic [31:0] reg_wd,
   output logic [31:0] WPC,
   output logic [31:0] pending,
   output logic [2:0]  fifo_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

   logic [AW-1:0]    r_wptr, r_rptr;
   logic [AW:0]      r_count;
   logic [4:0]       r_adr [DEPTH];
   logic [31:0]      r_wd  [DEPTH];
   logic [31:0]      r_pc  [DEPTH];
   logic [DEPTH-1:0] r_live;
   logic [31:0]      r_pending;

   logic        w_pipe_act, w_empty, w_full, w_pop, w_enq, w_squash, w_head_live;
   logic [31:0] w_pend_nxt;

   assign w_pipe_act  = pipe_we && (pipe_adr != 5'd0);
   assign w_empty     = (r_count == '0);
   assign w_full      = (r_count == L_FULL);
   assign w_head_live = !w_empty && r_live[r_rptr];
   assign w_pop       = !w_empty && !pause && !w_pipe_act;
   assign w_squash    = w_pipe_act && !pause;
   assign mdu_ready   = !w_full && !r_pending[mdu_adr];
   // Register 0 is dropped, and a same-edge pipeline write to the same register is younger.
   assign w_enq       = mdu_valid && mdu_ready && (mdu_adr != 5'd0) &&
                        !(w_pipe_act && (pipe_adr == mdu_adr));

   assign pending    = r_pending;
   assign fifo_count = 3'(r_count);

   always_comb begin
      reg_we   = 1'b0;
      reg_adr3 = '0;
      reg_wd   = '0;
      WPC      = '0;
      if (w_pipe_act) begin
         reg_we   = 1'b1;
         reg_adr3 = pipe_adr;
         reg_wd   = pipe_wd;
         WPC      = pipe_pc;
      end else if (w_head_live) begin
         reg_we   = 1'b1;
         reg_adr3 = r_adr[r_rptr];
         reg_wd   = r_wd[r_rptr];
         WPC      = r_pc[r_rptr];
      end
   end

   // At most one live entry per register exists, so clearing by address is exact.
   always_comb begin
      w_pend_nxt = r_pending;
      if (w_pop && w_head_live) w_pend_nxt[r_adr[r_rptr]] = 1'b0;
      if (w_squash)             w_pend_nxt[pipe_adr]      = 1'b0;
      if (w_enq)                w_pend_nxt[mdu_adr]       = 1'b1;
      w_pend_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
         r_live    <= '0;
         r_pending <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) r_adr[i] <= '0;
      end else begin
         r_pending <= w_pend_nxt;
         if (w_squash) begin
            for (int unsigned i = 0; i < DEPTH; i++)
               if (r_adr[i] == pipe_adr) r_live[i] <= 1'b0;
         end
         if (w_enq) begin
            r_adr[r_wptr]  <= mdu_adr;
            r_live[r_wptr] <= 1'b1;
            r_wptr         <= r_wptr + 1'b1;
         end
         if (w_pop) r_rptr <= r_rptr + 1'b1;
         case ({w_enq, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_wd[r_wptr] <= mdu_wd;
         r_pc[r_wptr] <= mdu_pc;
      end
   end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Bench for grf_wb_arbiter: directed scenarios then random traffic against a
// queue-based reference model and a shadow register file.
module tb_grf_wb_arbiter;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset, pause, pipe_we, mdu_valid;
   logic [4:0]  pipe_adr, mdu_adr;
   logic [31:0] pipe_wd, pipe_pc, mdu_wd, mdu_pc;
   logic        mdu_ready, reg_we;
   logic [4:0]  reg_adr3;
   logic [31:0] reg_wd, WPC, pending;
   logic [2:0]  fifo_count;

   grf_wb_arbiter #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .pause(pause),
      .pipe_we(pipe_we), .pipe_adr(pipe_adr), .pipe_wd(pipe_wd), .pipe_pc(pipe_pc),
      .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_adr(mdu_adr),
      .mdu_wd(mdu_wd), .mdu_pc(mdu_pc),
      .reg_we(reg_we), .reg_adr3(reg_adr3), .reg_wd(reg_wd), .WPC(WPC),
      .pending(pending), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  adr;
      logic [31:0] wd;
      logic [31:0] pc;
      bit          live;
   } ent_t;

   ent_t        q[$];
   logic [31:0] m_rf [32];
   logic [31:0] d_rf [32];
   int          nvec = 0;
   int          nfail = 0;

   function automatic logic [31:0] m_pending();
      logic [31:0] p = '0;
      foreach (q[i]) if (q[i].live) p[q[i].adr] = 1'b1;
      return p;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with inputs already driven; checks, then advances one clock.
   task automatic cycle();
      bit          act, e_we, pop, enq, e_rdy;
      logic [4:0]  e_adr;
      logic [31:0] e_wd, e_pc, e_pend;
      #1;
      if (reset) q.delete();
      act    = pipe_we && (pipe_adr != 0);
      e_pend = m_pending();
      e_rdy  = (q.size() < DEPTH) && !e_pend[mdu_adr];
      e_we = 0; e_adr = 0; e_wd = 0; e_pc = 0;
      if (act) begin
         e_we = 1; e_adr = pipe_adr; e_wd = pipe_wd; e_pc = pipe_pc;
      end else if (q.size() > 0 && q[0].live) begin
         e_we = 1; e_adr = q[0].adr; e_wd = q[0].wd; e_pc = q[0].pc;
      end
      chk("mdu_ready",  32'(mdu_ready),  32'(e_rdy));
      chk("reg_we",     32'(reg_we),     32'(e_we));
      chk("reg_adr3",   32'(reg_adr3),   32'(e_adr));
      chk("reg_wd",     reg_wd,          e_wd);
      chk("WPC",        WPC,             e_pc);
      chk("pending",    pending,         e_pend);
      chk("fifo_count", 32'(fifo_count), 32'(q.size()));
      if (!reset && !pause) begin
         if (reg_we) d_rf[reg_adr3] = reg_wd;
         if (e_we)   m_rf[e_adr]    = e_wd;
      end
      if (!reset) begin
         pop = (q.size() > 0) && !pause && !act;
         enq = mdu_valid && e_rdy && (mdu_adr != 0) && !(act && pipe_adr == mdu_adr);
         if (act && !pause)
            foreach (q[i]) if (q[i].adr == pipe_adr) q[i].live = 0;
         if (pop) void'(q.pop_front());
         if (enq) q.push_back('{adr: mdu_adr, wd: mdu_wd, pc: mdu_pc, live: 1'b1});
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      pause = 0; pipe_we = 0; pipe_adr = 0; pipe_wd = 0; pipe_pc = 0;
      mdu_valid = 0; mdu_adr = 0; mdu_wd = 0; mdu_pc = 0;
   endtask

   task automatic drv_pipe(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
      pipe_we = 1; pipe_adr = a; pipe_wd = d; pipe_pc = p;
   endtask

   task automatic drv_mdu(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
      mdu_valid = 1; mdu_adr = a; mdu_wd = d; mdu_pc = p;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin m_rf[i] = '0; d_rf[i] = '0; end
      reset = 1; idle();
      cycle();
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_we", 32'(reg_we), 32'd0);
      reset = 0;

      // Single MDU result on an idle pipeline.
      drv_mdu(5, 32'h1234, 32'h3000); cycle();
      idle(); cycle();
      cycle();
      chk("t1_rf5", d_rf[5], 32'h1234);

      // Fill while the pipeline hogs the port, then drain.
      drv_pipe(1, 32'h11, 32'h100);
      drv_mdu(3, 32'h33, 32'h200); cycle();
      drv_mdu(4, 32'h44, 32'h204); cycle();
      drv_mdu(6, 32'h66, 32'h208); cycle();
      drv_mdu(7, 32'h77, 32'h20C); cycle();
      drv_mdu(10, 32'hA0, 32'h210); cycle();
      chk("full_count", 32'(fifo_count), 32'd4);
      chk("full_ready", 32'(mdu_ready), 32'd0);
      idle();
      for (int i = 0; i < 5; i++) cycle();
      chk("drain_count", 32'(fifo_count), 32'd0);
      chk("drain_rf7", d_rf[7], 32'h77);

      // WAW squash of a queued result.
      drv_pipe(1, 32'h12, 32'h104); drv_mdu(8, 32'hAA, 32'h300); cycle();
      mdu_valid = 0; drv_pipe(8, 32'hBB, 32'h108); cycle();
      chk("sq_pending8", pending, 32'h0);
      idle(); cycle(); cycle();
      chk("sq_rf8", d_rf[8], 32'hBB);

      // Same-edge collision: MDU result is older and dropped.
      drv_pipe(9, 32'h99, 32'h10C); drv_mdu(9, 32'h90, 32'h304); cycle();
      idle(); cycle();
      chk("same_count", 32'(fifo_count), 32'd0);
      chk("same_rf9", d_rf[9], 32'h99);

      // Pause holds the queue; register 0 results vanish.
      drv_pipe(1, 32'h13, 32'h110); drv_mdu(12, 32'hC0, 32'h308); cycle();
      idle(); pause = 1;
      for (int i = 0; i < 3; i++) cycle();
      chk("pause_count", 32'(fifo_count), 32'd1);
      pause = 0; cycle();
      drv_mdu(0, 32'hDEAD, 32'h30C); cycle();
      idle(); cycle();
      chk("zero_count", 32'(fifo_count), 32'd0);
      chk("zero_rf0", d_rf[0], 32'h0);

      // Reset mid-drain.
      drv_pipe(1, 32'h14, 32'h114);
      drv_mdu(13, 32'hD0, 32'h310); cycle();
      drv_mdu(14, 32'hE0, 32'h314); cycle();
      drv_mdu(15, 32'hF0, 32'h318); cycle();
      idle(); drv_pipe(1, 32'h15, 32'h118); cycle();
      chk("pre_rst_count", 32'(fifo_count), 32'd3);
      idle(); reset = 1;
      cycle();
      reset = 0;
      cycle(); cycle();
      chk("post_rst_rf13", d_rf[13], 32'h0);

      // Random traffic on a few registers to provoke collisions.
      for (int n = 0; n < 400; n++) begin
         reset     = ($urandom_range(99) < 1);
         pause     = ($urandom_range(99) < 20);
         pipe_we   = ($urandom_range(99) < 40);
         pipe_adr  = 5'($urandom_range(7));
         pipe_wd   = $urandom; pipe_pc = $urandom;
         mdu_valid = ($urandom_range(99) < 60);
         mdu_adr   = 5'($urandom_range(7));
         mdu_wd    = $urandom; mdu_pc = $urandom;
         cycle();
      end
      reset = 0; idle();
      for (int i = 0; i < 8; i++) cycle();
      for (int i = 0; i < 32; i++) chk($sformatf("rf%0d", i), d_rf[i], m_rf[i]);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
